// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The slave side is the subtractor. The master side is whoever issues start.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output A,
        output B,
        output Bin,
        input  Diff,
        input  Bout,
        input  overflow,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        input  Bin,
        output Diff,
        output Bout,
        output overflow,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin. Operands are processed one bit per clock, LSB first, through a single
// full-subtractor stage. The results are published together with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Difference bit of one full-subtractor stage.
    function automatic logic fs_diff(input logic a, input logic b, input logic bw);
        return a ^ b ^ bw;
    endfunction

    // Borrow produced by one full-subtractor stage.
    function automatic logic fs_borrow(input logic a, input logic b, input logic bw);
        return (~a & b) | (~(a ^ b) & bw);
    endfunction

    state_e           state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic             bw_q,       bw_d;
    logic [WIDTH-1:0] res_q,      res_d;
    logic [WIDTH-1:0] diff_q,     diff_d;
    logic             bout_q,     bout_d;
    logic             ovf_q,      ovf_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic             bit_s;
    logic             borrow_s;
    logic [WIDTH-1:0] res_ins_s;

    // Current stage inputs are always at bit 0 of the operand shift registers.
    always_comb begin
        bit_s     = fs_diff(a_q[0], b_q[0], bw_q);
        borrow_s  = fs_borrow(a_q[0], b_q[0], bw_q);
        res_ins_s = res_q;
        res_ins_s[cnt_q] = bit_s;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        bw_d    = bw_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    bw_d    = bus.Bin;
                    cnt_d   = {CW{1'b0}};
                    res_d   = {WIDTH{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                bw_d  = borrow_s;
                res_d = res_ins_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // At the MSB, a_q[0] and b_q[0] still hold the sign bits of the latched operands.
                    state_d = DONE;
                    diff_d  = res_ins_s;
                    bout_d  = borrow_s;
                    ovf_d   = (a_q[0] ^ b_q[0]) & (bit_s ^ a_q[0]);
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            bw_q    <= 1'b0;
            res_q   <= {WIDTH{1'b0}};
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bw_q    <= bw_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Diff     = diff_q;
    assign bus.Bout     = bout_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// It uses a vector table, a scoreboard drained on done, and hand sequences for the timing corners.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];
    logic [W-1:0] prev_diff;
    vec_t vecs[10];

    serial_subtractor_if #(.WIDTH(W)) bus();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t        m;
        logic [W:0]  wide;
        wide   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        m.diff = wide[W-1:0];
        m.bout = wide[W];
        m.ovf  = (a[W-1] != b[W-1]) && (m.diff[W-1] != a[W-1]);
        return m;
    endfunction

    // Scoreboard monitor: each done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_diff", 32'(bus.Diff), 32'(e.diff));
                    chk("sb_bout", 32'(bus.Bout), 32'(e.bout));
                    chk("sb_ovf",  32'(bus.overflow), 32'(e.ovf));
                end
            end
        end
    end

    // One full operation with cycle-exact busy/done/hold checks.
    // If glitch is nonzero, a stray start is pulsed so that it is seen at that edge offset.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input exp_t e, input int glitch);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        sb_q.push_back(e);
        for (int j = 0; j <= W + 1; j++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = (glitch != 0 && j + 1 == glitch);
            if (glitch != 0 && j + 1 == glitch) begin
                bus.A = 8'h11;
                bus.B = 8'h22;
            end
            chk("busy", 32'(bus.busy), 32'(j < W));
            chk("done", 32'(bus.done), 32'(j == W));
            if (j < W) begin
                chk("diff_hold", 32'(bus.Diff), 32'(prev_diff));
            end
        end
        prev_diff = e.diff;
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;

        vecs[0] = '{8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[8] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[9] = '{8'h3C, 8'hC3, 1'b0, 8'h79, 1'b1, 1'b0};

        n_tests   = 0;
        n_fail    = 0;
        prev_diff = 8'h00;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = 8'h00;
        bus.B     = 8'h00;
        bus.Bin   = 1'b0;

        #1;
        chk("rst_diff", 32'(bus.Diff), 32'd0);
        chk("rst_bout", 32'(bus.Bout), 32'd0);
        chk("rst_ovf",  32'(bus.overflow), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            e = '{vecs[i].diff, vecs[i].bout, vecs[i].ovf};
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, e, 0);
        end

        // A stray start during SHIFT must not disturb the running operation.
        run_op(8'h50, 8'h30, 1'b0, '{8'h20, 1'b0, 1'b0}, 3);

        // Leave non-zero results, then reset in the middle of a new operation.
        run_op(8'h7F, 8'hFF, 1'b0, '{8'h80, 1'b1, 1'b1}, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h12;
        bus.B     = 8'h34;
        bus.Bin   = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_diff", 32'(bus.Diff), 32'd0);
        chk("midrst_bout", 32'(bus.Bout), 32'd0);
        chk("midrst_ovf",  32'(bus.overflow), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("rst_start_ignored", 32'(bus.busy), 32'd0);
        end
        rst_n     = 1'b1;
        bus.start = 1'b0;
        prev_diff = 8'h00;
        run_op(8'h50, 8'h30, 1'b0, '{8'h20, 1'b0, 1'b0}, 0);

        // start held high: back-to-back operations, each accepted at an IDLE edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h00;
        bus.B     = 8'h01;
        bus.Bin   = 1'b0;
        sb_q.push_back('{8'hFF, 1'b1, 1'b0});
        @(posedge clk);
        @(negedge clk);
        bus.A = 8'h80;
        bus.B = 8'h01;
        sb_q.push_back('{8'h7F, 1'b0, 1'b1});
        repeat (W + 2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_second_accepted", 32'(bus.busy), 32'd1);
        repeat (W + 3) @(negedge clk);
        chk("b2b_drained", 32'(sb_q.size()), 32'd0);
        prev_diff = 8'h7F;

        for (int i = 0; i < 6; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            run_op(ra, rb, rbin, model(ra, rb, rbin), 0);
        end

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
